// File: rtl/lcd_hd44780_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lcd_hd44780_if
// Write-only HD44780 character-LCD controller driving the 4-bit bus mode.
// After reset it waits for the panel to power up, then runs the 4-bit
// initialisation sequence (0x3,0x3,0x3,0x2 nibbles, then bytes 0x28, 0x0C,
// 0x01, 0x06). After that it accepts command/data bytes through a
// valid/ready handshake and sends each one as two nibbles, high nibble first.
// All timing comes from one shared down-counter, loaded with a wait length
// on entry to each timed state.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request to write in_data
//   in_rs      register select for the request (1 = data, 0 = command)
//   in_data    byte to write
//   in_ready   high in IDLE after init; a byte is taken when in_valid&&in_ready
//   init_done  high once the power-on init sequence has completed
//   busy       inverse of in_ready
//   E, RW, RS  HD44780 control lines (RW is tied low, writes only)
//   DB         HD44780 data lines DB7..DB4
// -----------------------------------------------------------------------------
module lcd_hd44780_if #(
  parameter int T_AS_CYC    = 20,
  parameter int T_EPW_CYC   = 100,
  parameter int T_NIB_CYC   = 200,
  parameter int T_CMD_CYC   = 10000,
  parameter int T_CLR_CYC   = 400000,
  parameter int T_PWR_CYC   = 3000000,
  parameter int T_INIT1_CYC = 820000,
  parameter int T_INIT2_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       busy,
  output logic       E,
  output logic       RW,
  output logic       RS,
  output logic [3:0] DB
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SEQ,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    POST
  } state_t;

  localparam logic [23:0] AS_W    = 24'(T_AS_CYC);
  localparam logic [23:0] EPW_W   = 24'(T_EPW_CYC);
  localparam logic [23:0] NIB_W   = 24'(T_NIB_CYC);
  localparam logic [23:0] CMD_W   = 24'(T_CMD_CYC);
  localparam logic [23:0] CLR_W   = 24'(T_CLR_CYC);
  localparam logic [23:0] PWR_W   = 24'(T_PWR_CYC);
  localparam logic [23:0] INIT1_W = 24'(T_INIT1_CYC);
  localparam logic [23:0] INIT2_W = 24'(T_INIT2_CYC);

  // Clear display (0x01) and return home (0x02/0x03) are the slow commands.
  function automatic logic [23:0] byte_wait(input logic rs, input logic [7:0] data);
    if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) return CLR_W;
    return CMD_W;
  endfunction

  // Steps 0..3 are single nibbles (carried in the high nibble), 4..7 full bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h20;
      3'd4:             return 8'h28;
      3'd5:             return 8'h0C;
      3'd6:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        lo_q, lo_d;          // low nibble is the one in flight
  logic        single_q, single_d;  // nibble-only transfer (early init)
  logic [23:0] post_q, post_d;      // POST wait chosen when the byte is loaded
  logic [2:0]  step_q, step_d;
  logic        init_done_q, init_done_d;
  logic        e_q, e_d;
  logic        rs_out_q, rs_out_d;
  logic [3:0]  db_q, db_d;

  logic        cnt_done;
  logic [7:0]  init_b;
  logic [23:0] init_w;

  // A state loaded with W lasts exactly W cycles: it leaves when the count is 1.
  assign cnt_done = (cnt_q == 24'd1);
  assign init_b   = init_byte(step_q);

  always_comb begin
    case (step_q)
      3'd0:    init_w = INIT1_W;
      3'd1:    init_w = INIT2_W;
      3'd2,
      3'd3:    init_w = CMD_W;
      default: init_w = byte_wait(1'b0, init_b);
    endcase
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    lo_d        = lo_q;
    single_d    = single_q;
    post_d      = post_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    e_d         = 1'b0;
    rs_out_d    = rs_out_q;
    db_d        = db_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_done) state_d = INIT_SEQ;
        else          cnt_d   = cnt_q - 24'd1;
      end

      INIT_SEQ: begin
        byte_d   = init_b;
        rs_d     = 1'b0;
        lo_d     = 1'b0;
        single_d = ~step_q[2];
        post_d   = init_w;
        rs_out_d = 1'b0;
        db_d     = init_b[7:4];
        cnt_d    = AS_W;
        state_d  = SETUP;
      end

      IDLE: begin
        if (in_valid && in_ready) begin
          byte_d   = in_data;
          rs_d     = in_rs;
          lo_d     = 1'b0;
          single_d = 1'b0;
          post_d   = byte_wait(in_rs, in_data);
          rs_out_d = in_rs;
          db_d     = in_data[7:4];
          cnt_d    = AS_W;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (cnt_done) begin
          e_d     = 1'b1;
          cnt_d   = EPW_W;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      PULSE: begin
        if (cnt_done) begin
          cnt_d   = NIB_W;
          state_d = HOLD;
        end else begin
          e_d   = 1'b1;
          cnt_d = cnt_q - 24'd1;
        end
      end

      HOLD: begin
        if (cnt_done) begin
          if (!single_q && !lo_q) begin
            lo_d     = 1'b1;
            db_d     = byte_q[3:0];
            rs_out_d = rs_q;
            cnt_d    = AS_W;
            state_d  = SETUP;
          end else begin
            cnt_d   = post_q;
            state_d = POST;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      POST: begin
        if (cnt_done) begin
          if (init_done_q || step_q == 3'd7) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = INIT_SEQ;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      default: state_d = PWR_WAIT;
    endcase
  end

  // Reset is asynchronous so E drops immediately, even in the middle of a pulse,
  // and any half-sent byte is discarded along with the init progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= PWR_W;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      lo_q        <= 1'b0;
      single_q    <= 1'b0;
      post_q      <= 24'd0;
      step_q      <= 3'd0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
      rs_out_q    <= 1'b0;
      db_q        <= 4'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values computed by the combinational block.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      lo_q        <= lo_d;
      single_q    <= single_d;
      post_q      <= post_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      e_q         <= e_d;
      rs_out_q    <= rs_out_d;
      db_q        <= db_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && init_done_q;
  assign busy      = ~in_ready;
  assign init_done = init_done_q;
  assign E         = e_q;
  assign RW        = 1'b0;
  assign RS        = rs_out_q;
  assign DB        = db_q;

endmodule

// File: tb/tb_lcd_hd44780_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lcd_hd44780_if
// Directed bench for lcd_hd44780_if with short timing parameters:
// T_AS=2, T_EPW=4, T_NIB=3, T_CMD=10, T_CLR=40, T_PWR=50, T_INIT1=30,
// T_INIT2=20. Cycle numbers are the count of rising edges seen so far;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lcd_hd44780_if;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       init_done;
  logic       busy;
  logic       E;
  logic       RW;
  logic       RS;
  logic [3:0] DB;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  lcd_hd44780_if #(
    .T_AS_CYC   (2),
    .T_EPW_CYC  (4),
    .T_NIB_CYC  (3),
    .T_CMD_CYC  (10),
    .T_CLR_CYC  (40),
    .T_PWR_CYC  (50),
    .T_INIT1_CYC(30),
    .T_INIT2_CYC(20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .in_ready (in_ready),
    .init_done(init_done),
    .busy     (busy),
    .E        (E),
    .RW       (RW),
    .RS       (RS),
    .DB       (DB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next E pulse; returns the nibble/RS seen at the rise and the
  // rise/fall cycle numbers. DB/RS must still hold their values after the fall.
  task automatic get_pulse(input string tag, output logic [3:0] db_o, output logic rs_o,
                           output int rise_o, output int fall_o);
    int n = 0;
    while (E !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_e_rise"}, 32'(E), 32'd1);
    db_o   = DB;
    rs_o   = RS;
    rise_o = cyc;
    n = 0;
    while (E === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    fall_o = cyc;
    check({tag, "_db_stable"}, 32'(DB), 32'(db_o));
    check({tag, "_rs_stable"}, 32'(RS), 32'(rs_o));
  endtask

  task automatic wait_ready(input string tag, output int t);
    int n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    t = cyc;
  endtask

  // Called on a falling edge with in_ready=1; the byte is taken on the next
  // rising edge, after which the inputs are scrambled to show they are ignored.
  task automatic send(input logic rs, input logic [7:0] data, input bit keep, output int acc);
    in_rs    = rs;
    in_data  = data;
    in_valid = 1'b1;
    @(negedge clk);
    acc      = cyc;
    in_valid = keep;
    in_rs    = ~rs;
    in_data  = ~data;
    check("ready_low_after_accept", 32'(in_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic rs, input logic [7:0] data,
                             input int acc, input int post);
    logic [3:0] d;
    logic       r;
    int rise1, fall1, rise2, fall2, rdy;
    get_pulse({tag, "_hi"}, d, r, rise1, fall1);
    check({tag, "_hi_setup"}, 32'(rise1 - acc), 32'd2);
    check({tag, "_hi_db"}, 32'(d), 32'(data[7:4]));
    check({tag, "_hi_rs"}, 32'(r), 32'(rs));
    check({tag, "_hi_width"}, 32'(fall1 - rise1), 32'd4);
    get_pulse({tag, "_lo"}, d, r, rise2, fall2);
    check({tag, "_lo_gap"}, 32'(rise2 - fall1), 32'd5);
    check({tag, "_lo_db"}, 32'(d), 32'(data[3:0]));
    check({tag, "_lo_rs"}, 32'(r), 32'(rs));
    check({tag, "_lo_width"}, 32'(fall2 - rise2), 32'd4);
    wait_ready(tag, rdy);
    check({tag, "_post_wait"}, 32'(rdy - fall2), 32'(3 + post));
  endtask

  // Full init: 12 pulses with fixed nibbles and gaps, then init_done and ready.
  task automatic expect_init(input string tag, input int rel);
    logic [3:0] exp_nib [12];
    int         exp_gap [12];
    logic [3:0] d;
    logic       r;
    int rise, fall, prev_fall, rdy;
    exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    // gap = rise(i) - fall(i-1) = hold(3) + post + dispatch(1) + setup(2),
    // or hold(3) + setup(2) between the two nibbles of a byte
    exp_gap = '{53, 36, 26, 16, 16, 5, 16, 5, 16, 5, 46, 5};
    prev_fall = rel;
    for (int i = 0; i < 12; i++) begin
      get_pulse($sformatf("%s_p%0d", tag, i), d, r, rise, fall);
      check($sformatf("%s_p%0d_gap", tag, i), 32'(rise - prev_fall), 32'(exp_gap[i]));
      check($sformatf("%s_p%0d_db", tag, i), 32'(d), 32'(exp_nib[i]));
      check($sformatf("%s_p%0d_rs", tag, i), 32'(r), 32'd0);
      check($sformatf("%s_p%0d_width", tag, i), 32'(fall - rise), 32'd4);
      check($sformatf("%s_p%0d_no_ready", tag, i), 32'(in_ready), 32'd0);
      check($sformatf("%s_p%0d_rw", tag, i), 32'(RW), 32'd0);
      prev_fall = fall;
    end
    wait_ready(tag, rdy);
    check({tag, "_last_post"}, 32'(rdy - prev_fall), 32'd13);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    int acc;
    int rel;
    int rdy;
    int n;
    logic saw_e;
    logic [7:0] burst [3];
    burst = '{8'h48, 8'h49, 8'h21};

    // Reset state, with a request already held to show it is not taken early
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h41;
    repeat (3) @(negedge clk);
    check("rst_E", 32'(E), 32'd0);
    check("rst_RW", 32'(RW), 32'd0);
    check("rst_RS", 32'(RS), 32'd0);
    check("rst_DB", 32'(DB), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Power-on wait plus init sequence; in_valid stays high throughout
    reset = 1'b0;
    rel   = cyc;
    expect_init("init", rel);

    // Held request 'A' is taken on the first ready cycle
    send(1'b1, 8'h41, 1'b0, acc);
    expect_byte("char_41", 1'b1, 8'h41, acc, 10);

    // Clear display is slow; the same byte as data is not
    send(1'b0, 8'h01, 1'b0, acc);
    expect_byte("cmd_clear", 1'b0, 8'h01, acc, 40);
    send(1'b1, 8'h01, 1'b0, acc);
    expect_byte("data_01", 1'b1, 8'h01, acc, 10);
    send(1'b0, 8'h02, 1'b0, acc);
    expect_byte("cmd_home", 1'b0, 8'h02, acc, 40);
    send(1'b0, 8'h04, 1'b0, acc);
    expect_byte("cmd_04", 1'b0, 8'h04, acc, 10);

    // in_valid held across three back-to-back bytes: one accept per IDLE visit
    for (int i = 0; i < 3; i++) begin
      send(1'b1, burst[i], (i < 2), acc);
      expect_byte($sformatf("burst%0d", i), 1'b1, burst[i], acc, 10);
    end
    saw_e = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      saw_e = saw_e | E;
    end
    check("burst_no_extra_pulse", 32'(saw_e), 32'd0);
    check("burst_idle_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a pulse
    send(1'b1, 8'h55, 1'b0, acc);
    n = 0;
    while (E !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_pulse", 32'(E), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_E_async", 32'(E), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_DB", 32'(DB), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel   = cyc;
    expect_init("reinit", rel);

    // Nothing of the aborted byte may appear afterwards
    saw_e = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      saw_e = saw_e | E;
    end
    check("reinit_no_residue", 32'(saw_e), 32'd0);
    wait_ready("reinit_idle", rdy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
